// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing handshake blocks.
package cdc_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

endpackage

// File: rtl/synchronizer_2ff.sv
// Flop-chain synchronizer for bringing asynchronous levels into the local clock domain.
module synchronizer_2ff
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle req/ack handshake: registers a word, flips req_o, and waits
// for the fast domain to echo the toggle on ack_i. Sticky err_o flags a missing acknowledge.
//
// Handshake: a word is accepted at a rising edge where ready_o=1 and valid_i=1; ready_o
// then stays low until the transfer completes, and valid_i/data_i are ignored meanwhile.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk_slow,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  req_o,
    input  logic                  ack_i,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  clr_err_i,
    output logic [15:0]           xfer_cnt_o,
    output state_t                state_o
);

    localparam logic [15:0] TO_MAX  = 16'(ACK_TIMEOUT);
    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] to_cnt_q;
    logic        ack_s;
    logic        ack_match;
    logic        timeout_evt;

    synchronizer_2ff #(
        .DATA_WIDTH(1)
    ) u_ack_sync (
        .clk   (clk_slow),
        .rst_ni(rst_ni),
        .d     (ack_i),
        .q     (ack_s)
    );

    // Phases agree once the receiver has echoed the latest request toggle.
    assign ack_match   = (ack_s == req_o);
    assign timeout_evt = (state_q == WAIT_ACK) && !ack_match && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk_slow or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ready_o    <= 1'b1;
            data_o     <= '0;
            req_o      <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            xfer_cnt_o <= 16'h0000;
            to_cnt_q   <= 16'h0000;
        end else begin
            done_o <= 1'b0;
            // A timeout on the same edge as a clear request keeps the flag set.
            if (timeout_evt) begin
                err_o <= 1'b1;
            end else if (clr_err_i) begin
                err_o <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        data_o   <= data_i;
                        req_o    <= ~req_o;
                        ready_o  <= 1'b0;
                        to_cnt_q <= 16'h0000;
                        state_q  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_match) begin
                        done_o     <= 1'b1;
                        ready_o    <= 1'b1;
                        xfer_cnt_o <= xfer_cnt_o + 16'd1;
                        state_q    <= IDLE;
                    end else if (to_cnt_q != TO_MAX) begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                default: begin
                    ready_o <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed steps with randomized data and receiver delays,
// a behavioural receiver in a fast clock domain and an accept/complete reference model.
module tb_cdc_handshake_tx;
    import cdc_pkg::*;

    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk_slow  = 1'b0;
    logic          clk_fast  = 1'b0;
    logic          rst_ni    = 1'b0;
    logic [DW-1:0] data_i    = '0;
    logic          valid_i   = 1'b0;
    logic          ack_i     = 1'b0;
    logic          clr_err_i = 1'b0;
    logic          ready_o, req_o, done_o, err_o;
    logic [DW-1:0] data_o;
    logic [15:0]   xfer_cnt_o;
    state_t        state_o;

    always #5 clk_slow = ~clk_slow;
    always #2 clk_fast = ~clk_fast;

    cdc_handshake_tx #(
        .DATA_WIDTH (DW),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk_slow  (clk_slow),
        .rst_ni    (rst_ni),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .req_o     (req_o),
        .ack_i     (ack_i),
        .done_o    (done_o),
        .err_o     (err_o),
        .clr_err_i (clr_err_i),
        .xfer_cnt_o(xfer_cnt_o),
        .state_o   (state_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Log of what was driven at each slow edge, indexed by cycle number.
    int            cyc = 0;
    logic [DW-1:0] drv_data [4096];
    logic          drv_valid[4096];

    always @(posedge clk_slow) begin
        cyc = cyc + 1;
        drv_data[cyc[11:0]]  = data_i;
        drv_valid[cyc[11:0]] = valid_i;
    end

    // Fast-domain receiver: echoes each request toggle after rx_delay fast cycles.
    logic [DW-1:0] exp_q[$];
    logic          rx_en    = 1'b1;
    logic          rx_seen  = 1'b0;
    int            rx_pend  = 0;
    int            rx_delay = 3;
    int            ack_cyc  = 0;

    always @(posedge clk_fast or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_i   = 1'b0;
            rx_seen = 1'b0;
            rx_pend = 0;
        end else begin
            if (req_o !== rx_seen) begin
                rx_seen = req_o;
                rx_pend = rx_delay;
            end else if (rx_pend > 0) begin
                rx_pend--;
            end
            if (rx_pend == 0 && rx_en && ack_i !== rx_seen) begin
                if (exp_q.size() == 0) check("rx_unexpected_req", 32'd1, 32'd0);
                else check("rx_data", 32'(data_o), 32'(exp_q.pop_front()));
                ack_i   = rx_seen;
                ack_cyc = cyc;
            end
        end
    end

    // Reference model: a word is taken whenever the block is free and valid was driven;
    // the block is busy until done is seen; the transfer count follows completions mod 2^16.
    logic          busy      = 1'b0;
    logic          prev_req  = 1'b0;
    logic [DW-1:0] held      = '0;
    logic [15:0]   model_cnt = 16'h0000;
    int            last_acc  = -1;
    int            acc_count = 0;
    int            done_cnt  = 0;
    logic          mon_got, mon_exp;

    always @(negedge clk_slow) begin
        if (!rst_ni) begin
            busy      = 1'b0;
            prev_req  = 1'b0;
            model_cnt = 16'h0000;
            last_acc  = -1;
            exp_q.delete();
        end else begin
            mon_exp = !busy && drv_valid[cyc[11:0]];
            mon_got = (req_o !== prev_req);
            check("accept_event", 32'(mon_got), 32'(mon_exp));
            if (mon_got) begin
                check("accept_data", 32'(data_o), 32'(drv_data[cyc[11:0]]));
                if (last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc >= 4), 32'd1);
                prev_req = req_o;
                busy     = 1'b1;
                held     = drv_data[cyc[11:0]];
                last_acc = cyc;
                acc_count++;
                exp_q.push_back(held);
            end else if (busy) begin
                check("hold_data", 32'(data_o), 32'(held));
            end
            if (done_o === 1'b1) begin
                check("done_in_wait", 32'(busy), 32'd1);
                busy      = 1'b0;
                model_cnt = model_cnt + 16'd1;
                done_cnt++;
            end
            check("ready", 32'(ready_o), 32'(!busy));
            check("xfer_cnt", 32'(xfer_cnt_o), 32'(model_cnt));
        end
    end

    task automatic send(input logic [DW-1:0] d);
        @(negedge clk_slow);
        #1;
        data_i  = d;
        valid_i = 1'b1;
        @(posedge clk_slow);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_done(input int max, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk_slow);
            if (done_o === 1'b1) seen = 1'b1;
        end
    endtask

    logic          seen;
    logic [DW-1:0] base;
    int            start_acc, start_done;

    initial begin
        // Reset state
        repeat (3) @(posedge clk_slow);
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_cnt", 32'(xfer_cnt_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        @(negedge clk_slow);
        #1 rst_ni = 1'b1;
        repeat (2) @(negedge clk_slow);

        // Single transfer, ack 3 fast cycles after the request
        rx_delay = 3;
        send(8'hA5);
        check("a5_data", 32'(data_o), 32'h0A5);
        check("a5_req", 32'(req_o), 32'd1);
        check("a5_ready_low", 32'(ready_o), 32'd0);
        wait_done(12, seen);
        check("a5_done_seen", 32'(seen), 32'd1);
        check("a5_done_latency", 32'((cyc - ack_cyc) inside {[2:3]}), 32'd1);
        @(negedge clk_slow);
        check("a5_done_pulse", 32'(done_o), 32'd0);
        check("a5_cnt", 32'(xfer_cnt_o), 32'd1);
        check("a5_ready_back", 32'(ready_o), 32'd1);

        // Continuous valid with incrementing data
        rx_en      = 1'b1;
        base       = DW'($urandom);
        start_acc  = acc_count;
        start_done = done_cnt;
        @(negedge clk_slow);
        #1 valid_i = 1'b1;
        for (int i = 0; i < 80; i++) begin
            data_i   = base + DW'(i);
            rx_delay = $urandom_range(2, 4);
            @(negedge clk_slow);
            #1;
        end
        valid_i = 1'b0;
        repeat (12) @(negedge clk_slow);
        check("burst_accepts_min", 32'(acc_count - start_acc >= 12), 32'd1);
        check("burst_done_eq_acc", 32'(done_cnt - start_done), 32'(acc_count - start_acc));
        check("burst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Missing acknowledge: timeout, late ack, then clear
        rx_en = 1'b0;
        send(DW'($urandom));
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk_slow);
            check("timeout_err", 32'(err_o), 32'(k == 8));
        end
        check("timeout_state", 32'(state_o), 32'(WAIT_ACK));
        repeat (3) @(negedge clk_slow);
        check("timeout_err_sticky", 32'(err_o), 32'd1);
        check("timeout_still_wait", 32'(state_o), 32'(WAIT_ACK));
        #1 rx_en = 1'b1;
        wait_done(10, seen);
        check("late_ack_done", 32'(seen), 32'd1);
        check("late_ack_err_kept", 32'(err_o), 32'd1);
        @(negedge clk_slow);
        #1 clr_err_i = 1'b1;
        @(negedge clk_slow);
        check("clr_err", 32'(err_o), 32'd0);
        #1 clr_err_i = 1'b0;

        // Clear request on the very edge the timeout fires
        rx_en = 1'b0;
        send(DW'($urandom));
        repeat (7) @(negedge clk_slow);
        @(negedge clk_slow);
        check("pre_timeout_err", 32'(err_o), 32'd0);
        #1 clr_err_i = 1'b1;
        @(negedge clk_slow);
        check("clr_vs_timeout", 32'(err_o), 32'd1);
        #1 clr_err_i = 1'b0;
        @(negedge clk_slow);
        check("clr_vs_timeout_hold", 32'(err_o), 32'd1);
        #1 rx_en = 1'b1;
        wait_done(10, seen);
        check("second_late_done", 32'(seen), 32'd1);

        // Transfer counter wrap
        @(negedge clk_slow);
        #1;
        force dut.xfer_cnt_o = 16'hFFFF;
        model_cnt = 16'hFFFF;
        #2 release dut.xfer_cnt_o;
        @(negedge clk_slow);
        check("wrap_preset", 32'(xfer_cnt_o), 32'h0FFFF);
        start_done = done_cnt;
        rx_delay   = 3;
        send(DW'($urandom));
        wait_done(12, seen);
        check("wrap_done", 32'(seen), 32'd1);
        @(negedge clk_slow);
        check("wrap_cnt", 32'(xfer_cnt_o), 32'd0);
        check("wrap_done_once", 32'(done_cnt - start_done), 32'd1);

        // Reset one cycle after an accept
        rx_en = 1'b0;
        send(8'h3C);
        check("mid_accept_data", 32'(data_o), 32'h03C);
        @(posedge clk_slow);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_o), 32'd0);
        check("mid_rst_req", 32'(req_o), 32'd0);
        check("mid_rst_ready", 32'(ready_o), 32'd1);
        check("mid_rst_done", 32'(done_o), 32'd0);
        check("mid_rst_err", 32'(err_o), 32'd0);
        check("mid_rst_cnt", 32'(xfer_cnt_o), 32'd0);
        check("mid_rst_state", 32'(state_o), 32'(IDLE));
        @(negedge clk_slow);
        #1;
        rst_ni   = 1'b1;
        rx_en    = 1'b1;
        rx_delay = 3;
        send(8'h11);
        check("post_rst_data", 32'(data_o), 32'h011);
        check("post_rst_req", 32'(req_o), 32'd1);
        wait_done(12, seen);
        check("post_rst_done", 32'(seen), 32'd1);
        @(negedge clk_slow);
        check("post_rst_cnt", 32'(xfer_cnt_o), 32'd1);
        check("post_rst_req_hold", 32'(req_o), 32'd1);

        repeat (3) @(negedge clk_slow);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
